// File: rtl/rect_fill_avalon.sv
// Avalon-MM rectangle-fill accelerator: a slave port holds corners and colour, and a master
// port streams one packed pixel write per covered, on-screen pixel into the VGA slave.
module rect_fill_avalon #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [31:0] VGA_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [7:0] XMax = 8'(SCREEN_W - 1);
  localparam logic [6:0] YMax = 7'(SCREEN_H - 1);

  localparam logic [3:0] AddrCtrl   = 4'd0;
  localparam logic [3:0] AddrP0     = 4'd1;
  localparam logic [3:0] AddrP1     = 4'd2;
  localparam logic [3:0] AddrColour = 4'd3;
  localparam logic [3:0] AddrCount  = 4'd4;

  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e state_q, state_d;

  // Software-visible registers
  logic [7:0]  x0_q, x1_q, colour_q;
  logic [6:0]  y0_q, y1_q;
  logic [14:0] count_q, count_d;

  // Working copies owned by the active fill
  logic [7:0]  wx0_q, wx0_d, wx1_q, wx1_d, wcol_q, wcol_d;
  logic [6:0]  wy0_q, wy0_d, wy1_q, wy1_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;

  logic        busy;
  logic        reg_we;
  logic        start;
  logic        accept;
  logic [7:0]  x1_clip;
  logic [6:0]  y1_clip;
  logic        unused_wdata;

  assign busy         = (state_q != StIdle);
  assign reg_we       = write && !busy;
  assign start        = reg_we && (address == AddrCtrl);
  assign accept       = (state_q == StDraw) && !master_waitrequest;
  assign x1_clip      = (wx1_q > XMax) ? XMax : wx1_q;
  assign y1_clip      = (wy1_q > YMax) ? YMax : wy1_q;
  assign unused_wdata = ^writedata[31:15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
    end else if (reg_we) begin
      unique case (address)
        AddrP0: begin
          x0_q <= writedata[7:0];
          y0_q <= writedata[14:8];
        end
        AddrP1: begin
          x1_q <= writedata[7:0];
          y1_q <= writedata[14:8];
        end
        AddrColour: colour_q <= writedata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      wx0_q   <= '0;
      wy0_q   <= '0;
      wx1_q   <= '0;
      wy1_q   <= '0;
      wcol_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wx0_q   <= wx0_d;
      wy0_q   <= wy0_d;
      wx1_q   <= wx1_d;
      wy1_q   <= wy1_d;
      wcol_q  <= wcol_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wx0_d   = wx0_q;
    wy0_d   = wy0_q;
    wx1_d   = wx1_q;
    wy1_d   = wy1_q;
    wcol_d  = wcol_q;
    cx_d    = cx_q;
    cy_d    = cy_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wx0_d   = x0_q;
          wy0_d   = y0_q;
          wx1_d   = x1_q;
          wy1_d   = y1_q;
          wcol_d  = colour_q;
          count_d = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        wx1_d = x1_clip;
        wy1_d = y1_clip;
        cx_d  = wx0_q;
        cy_d  = wy0_q;
        // An off-screen start corner always lands here as empty via the clipped compare
        if ((wx0_q > x1_clip) || (wy0_q > y1_clip)) begin
          state_d = StIdle;
        end else begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (accept) begin
          count_d = count_q + 15'd1;
          if (cx_q == wx1_q) begin
            cx_d = wx0_q;
            if (cy_q == wy1_q) begin
              state_d = StIdle;
            end else begin
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign master_address   = VGA_ADDR;
  assign master_write     = (state_q == StDraw);
  assign master_writedata = master_write ? {1'b0, cy_q, cx_q, 8'h00, wcol_q} : 32'h0;

  always_comb begin
    readdata = 32'h0;
    if (read) begin
      unique case (address)
        AddrCtrl:   readdata = {31'b0, busy};
        AddrP0:     readdata = {17'b0, y0_q, x0_q};
        AddrP1:     readdata = {17'b0, y1_q, x1_q};
        AddrColour: readdata = {24'b0, colour_q};
        AddrCount:  readdata = {17'b0, count_q};
        default:    readdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_avalon.sv
// Self-checking bench for rect_fill_avalon: vector table, hand-written corner sequences and
// random fills, each compared cycle by cycle against a pixel-list model of the fill.
module tb_rect_fill_avalon;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rect_fill_avalon dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .address            (address),
    .read               (read),
    .readdata           (readdata),
    .write              (write),
    .writedata          (writedata),
    .master_waitrequest (master_waitrequest),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata)
  );

  typedef struct {
    int          x0, y0, x1, y1;
    logic [7:0]  col;
    int          s_lo, s_hi;
    int          exp_n;
    int          exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle
  task automatic slave_write(input logic [3:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    read      = 1'b0;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic slave_read(input logic [3:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    #1;
    d    = readdata;
    read = 1'b0;
  endtask

  // mode: 0 plain, 1 CTRL poke in final-acceptance cycle, 2 CTRL poke in first idle cycle
  // (chains a fill), 3 register/CTRL writes mid-fill
  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [7:0] col, input int s_lo, input int s_hi,
                          input bit rnd, input int mode, input bit started,
                          input int exp_n, input int exp_busy, input string tag);
    logic [31:0] q[$];
    logic [31:0] rd;
    int          c;
    int          bcnt;
    int          n0;
    logic        wr;
    bit          chk_busy;
    bit          exp_idle;
    bit          exp_mw;
    logic [31:0] exp_wd;
    for (int y = y0; y <= y1 && y < 120; y++)
      for (int x = x0; x <= x1 && x < 160; x++)
        q.push_back({1'b0, 7'(y), 8'(x), 8'h00, col});
    n0 = q.size();
    if (exp_n >= 0) chk({tag, " model size"}, 32'(n0), 32'(exp_n));
    if (!started) begin
      slave_write(4'd1, 32'(((y0 & 127) << 8) | (x0 & 255)));
      slave_write(4'd2, 32'(((y1 & 127) << 8) | (x1 & 255)));
      slave_write(4'd3, {24'h0, col});
      slave_write(4'd0, 32'h0);
    end
    c    = 1;
    bcnt = 0;
    forever begin
      if (c > 20000) begin
        n_checks++;
        $display("FAIL %s timeout: fill still running, %0d pixels left", tag, q.size());
        break;
      end
      wr = rnd ? ($urandom_range(0, 3) == 0) : (c >= s_lo && c <= s_hi);
      master_waitrequest = wr;
      write    = 1'b0;
      address  = 4'd0;
      read     = 1'b1;
      chk_busy = 1'b1;
      exp_idle = (c >= 2) && (q.size() == 0);
      if (mode == 3 && c == 3) begin
        address = 4'd1; writedata = 32'h0101; write = 1'b1; chk_busy = 1'b0;
      end
      if (mode == 3 && c == 4) begin
        address = 4'd3; writedata = 32'h9; write = 1'b1; chk_busy = 1'b0;
      end
      if (mode == 3 && c == 5) begin
        writedata = 32'h0; write = 1'b1;
      end
      if (mode == 1 && c >= 2 && q.size() == 1 && !wr) write = 1'b1;
      if (mode == 2 && exp_idle) write = 1'b1;
      @(negedge clk);
      exp_mw = (c >= 2) && (q.size() > 0);
      exp_wd = exp_mw ? q[0] : 32'h0;
      if (chk_busy) begin
        chk({tag, " busy"}, readdata, {31'b0, !exp_idle});
        if (readdata[0]) bcnt++;
      end
      chk({tag, " master_write"}, 32'(master_write), 32'(exp_mw));
      chk({tag, " master_writedata"}, master_writedata, exp_wd);
      chk({tag, " master_address"}, master_address, 32'h0);
      if (exp_mw && !wr) void'(q.pop_front());
      if (exp_idle) break;
      @(posedge clk);
      #1;
      c++;
    end
    @(posedge clk);
    #1;
    write              = 1'b0;
    master_waitrequest = 1'b0;
    if (mode != 2) begin
      address = 4'd0;
      read    = 1'b1;
      @(negedge clk);
      chk({tag, " stays idle"}, readdata, 32'h0);
      chk({tag, " no extra write"}, 32'(master_write), 32'h0);
      read = 1'b0;
      if (exp_busy >= 0) chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_busy));
      @(posedge clk);
      #1;
      slave_read(4'd4, rd);
      chk({tag, " COUNT"}, rd, 32'(n0));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          rx0, ry0, rx1, ry1;

    tbl[0] = '{10, 20, 12, 21, 8'h05, 0, -1, 6, 7};
    tbl[1] = '{10, 20, 12, 21, 8'h05, 3, 5, 6, 10};
    tbl[2] = '{150, 115, 200, 127, 8'hAA, 0, -1, 50, 51};
    tbl[3] = '{30, 0, 20, 0, 8'h11, 0, -1, 0, 1};
    tbl[4] = '{170, 0, 175, 0, 8'h22, 0, -1, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 8'h01, 0, -1, 1, 2};
    tbl[6] = '{5, 100, 5, 127, 8'h03, 0, -1, 20, 21};

    reset_n            = 1'b0;
    address            = 4'd0;
    read               = 1'b0;
    write              = 1'b0;
    writedata          = 32'h0;
    master_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    chk("reset master_write", 32'(master_write), 32'h0);
    chk("reset master_writedata", master_writedata, 32'h0);
    chk("reset master_address", master_address, 32'h0);
    for (int a = 0; a < 6; a++) begin
      slave_read(4'(a), rd);
      chk($sformatf("reset reg %0d", a), rd, 32'h0);
    end

    slave_write(4'd1, 32'h0000_1234);
    slave_read(4'd1, rd);
    chk("P0 readback", rd, 32'h0000_1234);
    slave_write(4'd2, 32'hFFFF_FFFF);
    slave_read(4'd2, rd);
    chk("P1 readback masked", rd, 32'h0000_7FFF);
    slave_write(4'd3, 32'h0000_ABCD);
    slave_read(4'd3, rd);
    chk("COLOUR readback", rd, 32'h0000_00CD);
    slave_read(4'd9, rd);
    chk("unmapped read", rd, 32'h0);
    address = 4'd1;
    read    = 1'b0;
    #1;
    chk("readdata with read low", readdata, 32'h0);

    for (int i = 0; i < 7; i++)
      run_fill(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].col, tbl[i].s_lo,
               tbl[i].s_hi, 1'b0, 0, 1'b0, tbl[i].exp_n, tbl[i].exp_busy,
               $sformatf("vec%0d", i));

    // Mid-fill writes must not disturb the active fill or the stored registers
    run_fill(10, 20, 12, 21, 8'h05, 0, -1, 1'b0, 3, 1'b0, 6, -1, "midwrite");
    slave_read(4'd1, rd);
    chk("midwrite P0 kept", rd, 32'h0000_140A);
    slave_read(4'd3, rd);
    chk("midwrite COLOUR kept", rd, 32'h0000_0005);

    // CTRL write coinciding with the final acceptance is dropped
    run_fill(3, 3, 4, 3, 8'h07, 0, -1, 1'b0, 1, 1'b0, 2, 3, "lastpoke");

    // CTRL write in the first idle cycle starts the next fill
    run_fill(2, 2, 3, 3, 8'h44, 0, -1, 1'b0, 2, 1'b0, 4, -1, "chain_a");
    run_fill(2, 2, 3, 3, 8'h44, 0, -1, 1'b0, 0, 1'b1, 4, 5, "chain_b");

    for (int i = 0; i < 10; i++) begin
      rx0 = int'($urandom_range(0, 175));
      rx1 = rx0 + int'($urandom_range(0, 12)) - 2;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 255) rx1 = 255;
      ry0 = int'($urandom_range(0, 124));
      ry1 = ry0 + int'($urandom_range(0, 4)) - 1;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 127) ry1 = 127;
      run_fill(rx0, ry0, rx1, ry1, 8'($urandom), 0, -1, 1'b1, 0, 1'b0, -1, -1,
               $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of DRAW
    slave_write(4'd1, 32'h0000_0000);
    slave_write(4'd2, 32'h0000_0514);
    slave_write(4'd3, 32'h0000_0033);
    slave_write(4'd0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset drawing", 32'(master_write), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async reset master_write", 32'(master_write), 32'h0);
    chk("async reset master_writedata", master_writedata, 32'h0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 5; a++) begin
      slave_read(4'(a), rd);
      chk($sformatf("post-reset reg %0d", a), rd, 32'h0);
    end
    run_fill(10, 20, 12, 21, 8'h05, 0, -1, 1'b0, 0, 1'b0, 6, 7, "post-reset fill");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rect_fill_avalon.md
# rect_fill_avalon

Avalon-MM rectangle-fill accelerator, directly upstream of the VGA Avalon slave. Software programs corner coordinates and a colour through a slave port and starts the fill. The block then uses its Avalon master port to stream one pixel-write per covered pixel into the VGA slave's register 0, packing y into [30:24], x into [23:16] and colour into [7:0]. It runs at one pixel per cycle when the VGA side does not stall.

## Interface
- SCREEN_W, 160: visible width. Columns at or above this value are clipped.
- SCREEN_H, 120: visible height. Rows at or above this value are clipped.
- VGA_ADDR, 32'h0: constant byte address driven on master_address, pointing at the VGA slave's pixel register.

Ports:
- clk  in  1  clock for all state.
- reset_n  in  1  asynchronous active-low reset.
- address  in  4  slave word address.
- read  in  1  slave read strobe.
- readdata  out  32  slave read data, zero-latency (combinational on address/read).
- write  in  1  slave write strobe.
- writedata  in  32  slave write data.
- master_waitrequest  in  1  downstream stall.
- master_address  out  32  always VGA_ADDR.
- master_write  out  1  pixel write request.
- master_writedata  out  32  {1'b0, y[6:0], x[7:0], 8'b0, colour[7:0]}.

## Operation
Slave registers (word address):
- 0 CTRL: a write starts a fill if idle (data ignored). Read returns {31'b0, busy}.
- 1 P0: write [7:0]=x0, [14:8]=y0.
- 2 P1: write [7:0]=x1, [14:8]=y1. The rectangle is inclusive of both corners.
- 3 COLOUR: write [7:0].
- 4 COUNT: read {17'b0, count[14:0]}, the pixels accepted by the downstream in the current or last fill.

Register access rules:
- Reads of P0, P1 and COLOUR return the stored fields, zero-extended.
- Unmapped addresses read as 0.
- readdata is 0 whenever read is low.
- While busy, writes to addresses 0–3 are ignored entirely; they neither queue nor alter the active fill.

FSM:
- IDLE: on a CTRL write, latch working copies of the registers, clear COUNT, and go to SETUP.
- SETUP (1 cycle): clip x1 to min(x1, SCREEN_W-1) and y1 to min(y1, SCREEN_H-1).
  - If x0>x1 or y0>y1 after clipping, the fill is empty: return to IDLE and leave COUNT at 0.
  - Otherwise set cx=x0, cy=y0 and go to DRAW.
  - An x0 or y0 beyond the screen always yields an empty fill through this comparison.
- DRAW: drive master_write=1 with the packed (cx, cy, colour).
  - The transfer is accepted in a cycle where master_waitrequest=0. On acceptance COUNT increments.
  - Traversal is raster order: cx increments; when cx==x1, cx wraps to x0 and cy increments.
  - Acceptance of (x1, y1) returns the FSM to IDLE.
- busy = (state != IDLE).

Master rules:
- While master_waitrequest=1, master_write, master_address and master_writedata hold stable.
- No pixel is skipped or duplicated.

## Timing
- Reset values: state IDLE; P0, P1, COLOUR and COUNT = 0; busy 0; master_write 0; master_writedata 0; readdata 0. master_address is VGA_ADDR at all times.
- Reset is asynchronous. Asserting reset_n low mid-fill drops master_write immediately and abandons the fill; no resume on release.
- Start latency: CTRL write sampled at edge N → busy reads 1 from cycle N+1 (SETUP) → first master_write=1 in cycle N+2.
- Throughput: 1 pixel per cycle with no stall. Each stalled cycle adds one cycle.
- A W×H fill with no stalls occupies 1+W·H busy cycles.
- busy returns to 0 in the cycle after the last acceptance. A new CTRL write in that cycle is honoured.
- A CTRL write in the same cycle as the final acceptance is ignored, because the block is still busy.
- Empty fill: busy is high for exactly 1 cycle (SETUP), and no master_write is issued.
- COUNT width is 15 bits; the maximum value is 19200.

## Test plan
- Fill (10,20)–(12,21), colour 5, no stall: expect 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with writedata e.g. 32'h140A0005 first. First write appears 2 cycles after start; busy is high for 7 cycles; COUNT=6.
- Same fill with master_waitrequest held high for 3 cycles on the 2nd pixel: the data for (11,20) holds stable across the stall; total busy is 10 cycles; there are still exactly 6 acceptances.
- Fill (150,115)–(200,127): clipped to (150..159)×(115..119); 50 writes; the last is (159,119); no x≥160 or y≥120 ever appears.
- Fill with x0=30, x1=20: busy is high for 1 cycle, no master_write, COUNT=0. Same result for x0=170, y0=0, x1=175, y1=0.
- Writes to P0 and COLOUR plus a second CTRL write mid-fill: the ongoing pixels are unchanged, no second fill starts, and readback of P0 shows the pre-fill value.
- reset_n pulsed low during DRAW: master_write drops asynchronously; all registers read 0 after release; a fresh fill then runs correctly.
